fruit_life_ctrl: RTL and testbench

- Downstream consumer of the fruit bounce mover. Owns the fruit lifecycle: hanging and bobbing on the vine, released by a player touch, falling under gravity, scoring on an enemy hit, and respawning after a delay.
- Takes the mover's bobbing Y position and collision pulses from the collision matrix.
- Drives the final fruit topLeftY, visibility and a score pulse into the object drawer and the score counter.
- Runs at frame rate; the only timebase is startOfFrame.

---
 rtl/fruit_pkg.sv | 9 +
 rtl/fruit_life_ctrl_if.sv | 23 ++
 rtl/fruit_frame_timer.sv | 30 +++
 rtl/fruit_life_ctrl.sv | 111 +++++++++++
 tb/tb_fruit_life_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fruit_pkg.sv
// Shared types and constants for the fruit lifecycle controller.
package fruit_pkg;

    typedef enum logic [1:0] {HANGING, FALLING, HIT, RESPAWN_WAIT} fruit_state_t;

    localparam int FIXED_POINT_MULTIPLIER = 128;
    localparam int FRAME_CNT_W = 6;

endpackage

// File: rtl/fruit_life_ctrl_if.sv
// Fruit controller bus: mover/collision inputs and drawer/score outputs.
interface fruit_life_ctrl_if;

    logic               startOfFrame;
    logic signed [10:0] bounceTopLeftY;
    logic               collisionPlayerFruit;
    logic               collisionFruitEnemy;
    logic signed [10:0] topLeftY;
    logic               fruitVisible;
    logic               scorePulse;
    logic               falling;

    modport master (
        output startOfFrame, bounceTopLeftY, collisionPlayerFruit, collisionFruitEnemy,
        input  topLeftY, fruitVisible, scorePulse, falling
    );

    modport slave (
        input  startOfFrame, bounceTopLeftY, collisionPlayerFruit, collisionFruitEnemy,
        output topLeftY, fruitVisible, scorePulse, falling
    );

endinterface

// File: rtl/fruit_frame_timer.sv
// Frame counter shared by the blink and respawn periods; wraps to zero at limit.
module fruit_frame_timer #(
    parameter int WIDTH     = 6,
    parameter int PHASE_BIT = 2
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             tick,
    input  logic             clear,
    input  logic [WIDTH-1:0] limit,
    output logic             phase,
    output logic             done
);

    logic [WIDTH-1:0] count;

    assign done  = tick && !clear && (count == limit);
    assign phase = count[PHASE_BIT];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else if (clear || done) begin
            count <= '0;
        end else if (tick) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fruit_life_ctrl.sv
// Fruit lifecycle: hang on the vine, fall under gravity, score on enemy hit, respawn.
module fruit_life_ctrl
    import fruit_pkg::*;
#(
    parameter int FLOOR_Y        = 464,
    parameter int GRAVITY        = 16,
    parameter int MAX_FALL_SPEED = 640,
    parameter int HIT_FRAMES     = 16,
    parameter int RESPAWN_FRAMES = 60
) (
    input  logic              clk,
    input  logic              resetN,
    fruit_life_ctrl_if.slave  bus
);

    localparam logic signed [31:0] FLOOR_FIXED = 32'(FLOOR_Y * FIXED_POINT_MULTIPLIER);

    fruit_state_t       state;
    logic signed [31:0] pos_fixed;
    logic signed [31:0] speed;
    logic signed [31:0] speed_sum;
    logic signed [31:0] speed_next;
    logic signed [31:0] bounce_fixed;
    logic               score_pulse;
    logic               falling_r;

    logic                   timer_clear;
    logic [FRAME_CNT_W-1:0] timer_limit;
    logic                   blink_phase;
    logic                   frame_done;

    assign bounce_fixed = {{14{bus.bounceTopLeftY[10]}}, bus.bounceTopLeftY, 7'd0};
    assign speed_sum    = speed + GRAVITY;
    assign speed_next   = (speed_sum > MAX_FALL_SPEED) ? 32'(MAX_FALL_SPEED) : speed_sum;

    // Timer is held cleared outside the counted states, so every entry starts at zero.
    assign timer_clear = (state == HANGING) || (state == FALLING);
    assign timer_limit = (state == HIT) ? FRAME_CNT_W'(HIT_FRAMES - 1)
                                        : FRAME_CNT_W'(RESPAWN_FRAMES - 1);

    fruit_frame_timer #(
        .WIDTH     (FRAME_CNT_W),
        .PHASE_BIT (2)
    ) u_frame_timer (
        .clk    (clk),
        .resetN (resetN),
        .tick   (bus.startOfFrame),
        .clear  (timer_clear),
        .limit  (timer_limit),
        .phase  (blink_phase),
        .done   (frame_done)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= HANGING;
            pos_fixed   <= '0;
            speed       <= '0;
            score_pulse <= 1'b0;
            falling_r   <= 1'b0;
        end else begin
            score_pulse <= 1'b0;
            case (state)
                HANGING: begin
                    if (bus.collisionPlayerFruit) begin
                        state     <= FALLING;
                        pos_fixed <= bounce_fixed;
                        speed     <= '0;
                        falling_r <= 1'b1;
                    end
                end
                FALLING: begin
                    // Enemy hit outranks the floor check and freezes the position.
                    if (bus.collisionFruitEnemy) begin
                        state       <= HIT;
                        score_pulse <= 1'b1;
                        falling_r   <= 1'b0;
                    end else if (pos_fixed >= FLOOR_FIXED) begin
                        state     <= RESPAWN_WAIT;
                        falling_r <= 1'b0;
                    end else if (bus.startOfFrame) begin
                        pos_fixed <= pos_fixed + speed;
                        speed     <= speed_next;
                    end
                end
                HIT: begin
                    if (frame_done) state <= RESPAWN_WAIT;
                end
                RESPAWN_WAIT: begin
                    if (frame_done) state <= HANGING;
                end
                default: state <= HANGING;
            endcase
        end
    end

    always_comb begin
        bus.fruitVisible = 1'b1;
        case (state)
            HIT:          bus.fruitVisible = ~blink_phase;
            RESPAWN_WAIT: bus.fruitVisible = 1'b0;
            default:      bus.fruitVisible = 1'b1;
        endcase
    end

    assign bus.topLeftY   = (state == HANGING) ? bus.bounceTopLeftY
                                               : 11'(pos_fixed / FIXED_POINT_MULTIPLIER);
    assign bus.scorePulse = score_pulse;
    assign bus.falling    = falling_r;

endmodule

// File: tb/tb_fruit_life_ctrl.sv
// Self-checking bench for fruit_life_ctrl: vector table, directed corners, random vs model.
module tb_fruit_life_ctrl;

    logic clk;
    logic resetN;
    int   total;
    int   bad;

    fruit_life_ctrl_if bus();

    fruit_life_ctrl #(
        .FLOOR_Y        (464),
        .GRAVITY        (16),
        .MAX_FALL_SPEED (640),
        .HIT_FRAMES     (16),
        .RESPAWN_FRAMES (60)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: lifecycle phase, position in 1/128 px, speed, frames spent in phase.
    typedef enum int {M_HANG, M_FALL, M_HIT, M_WAIT} mstate_t;
    mstate_t m_st;
    int      m_pos;
    int      m_speed;
    int      m_frames;
    bit      m_score;

    task automatic model_reset();
        m_st = M_HANG; m_pos = 0; m_speed = 0; m_frames = 0; m_score = 0;
    endtask

    task automatic model_step();
        bit sof;
        sof = bus.startOfFrame;
        m_score = 0;
        case (m_st)
            M_HANG: if (bus.collisionPlayerFruit) begin
                m_st = M_FALL; m_pos = int'(bus.bounceTopLeftY) * 128; m_speed = 0;
            end
            M_FALL: begin
                if (bus.collisionFruitEnemy) begin
                    m_st = M_HIT; m_score = 1; m_frames = 0;
                end else if (m_pos >= 464 * 128) begin
                    m_st = M_WAIT; m_frames = 0;
                end else if (sof) begin
                    m_pos = m_pos + m_speed;
                    m_speed = (m_speed + 16 > 640) ? 640 : m_speed + 16;
                end
            end
            M_HIT: if (sof) begin
                m_frames++;
                if (m_frames == 16) begin m_st = M_WAIT; m_frames = 0; end
            end
            M_WAIT: if (sof) begin
                m_frames++;
                if (m_frames == 60) begin m_st = M_HANG; m_frames = 0; end
            end
            default: m_st = M_HANG;
        endcase
    endtask

    function automatic int model_y();
        logic signed [10:0] t;
        if (m_st == M_HANG) return int'(bus.bounceTopLeftY);
        t = 11'(m_pos / 128);
        return int'(t);
    endfunction

    function automatic int model_vis();
        if (m_st == M_WAIT) return 0;
        if (m_st == M_HIT) return ((m_frames / 4) % 2 == 0) ? 1 : 0;
        return 1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("model topLeftY", int'(bus.topLeftY), model_y());
        chk("model fruitVisible", int'(bus.fruitVisible), model_vis());
        chk("model falling", int'(bus.falling), (m_st == M_FALL) ? 1 : 0);
        chk("model scorePulse", int'(bus.scorePulse), int'(m_score));
    endtask

    task automatic cycle(input bit sof, input bit player, input bit enemy);
        bus.startOfFrame = sof;
        bus.collisionPlayerFruit = player;
        bus.collisionFruitEnemy = enemy;
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic frame(input bit player, input bit enemy);
        cycle(1'b1, player, enemy);
        cycle(1'b0, player, enemy);
    endtask

    task automatic set_y(input int y);
        bus.bounceTopLeftY = 11'(y);
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        bus.startOfFrame = 1'b0;
        bus.collisionPlayerFruit = 1'b0;
        bus.collisionFruitEnemy = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b1;
    endtask

    typedef struct {
        bit sof; int bounce; bit player; bit enemy;
        int y; bit vis; bit fall; bit score;
    } vec_t;
    vec_t vecs[9];

    int pulses;

    initial begin
        total = 0;
        bad = 0;
        resetN = 1'b0;
        set_y(300);

        vecs[0] = '{0,  300, 0, 0, 300, 1, 0, 0};
        vecs[1] = '{1,  -20, 0, 0, -20, 1, 0, 0};
        vecs[2] = '{0,  100, 0, 1, 100, 1, 0, 0};
        vecs[3] = '{0,  300, 1, 0, 300, 1, 1, 0};
        vecs[4] = '{1,   50, 1, 0, 300, 1, 1, 0};
        vecs[5] = '{1,   50, 0, 0, 300, 1, 1, 0};
        vecs[6] = '{0,   50, 0, 1, 300, 1, 0, 1};
        vecs[7] = '{0,   50, 0, 1, 300, 1, 0, 0};
        vecs[8] = '{1,   50, 0, 0, 300, 1, 0, 0};

        // Reset state and table-driven basic behaviour
        do_reset();
        chk("reset fruitVisible", int'(bus.fruitVisible), 1);
        chk("reset falling", int'(bus.falling), 0);
        chk("reset scorePulse", int'(bus.scorePulse), 0);
        chk("reset passthrough", int'(bus.topLeftY), 300);
        for (int i = 0; i < 9; i++) begin
            set_y(vecs[i].bounce);
            cycle(vecs[i].sof, vecs[i].player, vecs[i].enemy);
            chk($sformatf("vec%0d topLeftY", i), int'(bus.topLeftY), vecs[i].y);
            chk($sformatf("vec%0d fruitVisible", i), int'(bus.fruitVisible), int'(vecs[i].vis));
            chk($sformatf("vec%0d falling", i), int'(bus.falling), int'(vecs[i].fall));
            chk($sformatf("vec%0d scorePulse", i), int'(bus.scorePulse), int'(vecs[i].score));
        end

        // Release and fall to the floor
        do_reset();
        set_y(300);
        cycle(1'b0, 1'b1, 1'b0);
        chk("release falling", int'(bus.falling), 1);
        for (int f = 1; f <= 54; f++) begin
            frame(1'b0, 1'b0);
            if (f == 1)  chk("fall f1 topLeftY", int'(bus.topLeftY), 300);
            if (f == 41) chk("fall f41 topLeftY", int'(bus.topLeftY), 402);
            if (f == 53) chk("fall f53 still falling", int'(bus.falling), 1);
        end
        chk("floor falling", int'(bus.falling), 0);
        chk("floor fruitVisible", int'(bus.fruitVisible), 0);
        chk("floor scorePulse", int'(bus.scorePulse), 0);

        // Enemy kill with held collision, then blink period
        do_reset();
        set_y(300);
        cycle(1'b0, 1'b1, 1'b0);
        repeat (5) frame(1'b0, 1'b0);
        chk("kill pre topLeftY", int'(bus.topLeftY), 301);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 1'b1);
            pulses += int'(bus.scorePulse);
        end
        chk("kill pulse count", pulses, 1);
        chk("kill frozen topLeftY", int'(bus.topLeftY), 301);
        for (int f = 1; f <= 16; f++) begin
            frame(1'b0, 1'b1);
            if (f == 4)  chk("blink f4 fruitVisible", int'(bus.fruitVisible), 0);
            if (f == 8)  chk("blink f8 fruitVisible", int'(bus.fruitVisible), 1);
            if (f == 16) chk("blink f16 fruitVisible", int'(bus.fruitVisible), 0);
        end
        chk("kill frozen after blink", int'(bus.topLeftY), 301);

        // Enemy hit in the same clk the floor is crossed
        do_reset();
        set_y(300);
        cycle(1'b0, 1'b1, 1'b0);
        repeat (53) frame(1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        chk("simul scorePulse", int'(bus.scorePulse), 1);
        chk("simul fruitVisible", int'(bus.fruitVisible), 1);
        chk("simul falling", int'(bus.falling), 0);

        // Respawn with player collisions ignored while waiting
        repeat (16) frame(1'b0, 1'b0);
        for (int f = 1; f <= 60; f++) begin
            frame(f < 60, 1'b0);
            if (f == 59) chk("respawn f59 fruitVisible", int'(bus.fruitVisible), 0);
        end
        chk("respawn fruitVisible", int'(bus.fruitVisible), 1);
        chk("respawn falling", int'(bus.falling), 0);
        set_y(77);
        cycle(1'b0, 1'b0, 1'b0);
        chk("respawn track 77", int'(bus.topLeftY), 77);
        set_y(200);
        cycle(1'b0, 1'b0, 1'b0);
        chk("respawn track 200", int'(bus.topLeftY), 200);

        // Asynchronous reset mid-fall
        set_y(300);
        cycle(1'b0, 1'b1, 1'b0);
        repeat (20) frame(1'b0, 1'b0);
        chk("midfall falling before", int'(bus.falling), 1);
        #2;
        resetN = 1'b0;
        #1;
        chk("midfall async falling", int'(bus.falling), 0);
        chk("midfall async scorePulse", int'(bus.scorePulse), 0);
        chk("midfall async fruitVisible", int'(bus.fruitVisible), 1);
        model_reset();
        set_y(250);
        bus.collisionPlayerFruit = 1'b0;
        #1;
        chk("midfall passthrough", int'(bus.topLeftY), 250);
        @(negedge clk);
        resetN = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) set_y(int'($urandom_range(0, 600)) - 100);
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
